wishbone_slave_regs: RTL and testbench

WISHBONE_SLAVE_REGS -- requirements
Module: wishbone_slave_regs

---
 rtl/wishbone_slave_regs.sv | 278 +++++++++++++++++++++++++++
 tb/tb_wishbone_slave_regs.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_slave_regs.sv
// ============================================================================
// wishbone_slave_regs
// ----------------------------------------------------------------------------
// Wishbone classic responder backed by 16 x 32-bit registers.
//   - Registers 0..14 are read/write with per-byte-lane write selects.
//   - Register 15 is read-only and returns ID_VALUE; writes to it are acked
//     and discarded.
//   - Each transfer is captured in IDLE, held for WAIT_STATES cycles in WAIT,
//     then terminated for exactly one cycle in RESP.
//   - Addresses with wb_adr_i[7:6] != 0 are out of range: never written, read
//     back as zero.
//
// Optional feature (macro WB_SLAVE_ERR_EN):
//   defined   : out-of-range transfers terminate with wb_err_o.
//   undefined : out-of-range transfers terminate with wb_ack_o and
//               wb_err_o is tied low.
//
// Parameters
//   WAIT_STATES : wait cycles inserted before each response (0..7)
//   ID_VALUE    : contents of read-only register 15
//
// Ports
//   clk                    : single clock, rising edge
//   reset                  : asynchronous, active-high reset
//   wb_cyc_i / wb_stb_i    : Wishbone cycle / strobe
//   wb_we_i                : 1 = write
//   wb_adr_i[7:0]          : byte address ([5:2] register, [7:6] range check)
//   wb_dat_i[31:0]         : write data
//   wb_sel_i[3:0]          : byte lane selects
//   wb_dat_o[31:0]         : read data (zero outside RESP of an in-range read)
//   wb_ack_o / wb_err_o    : normal / error termination
//   scan_in0..4, scan_enable, test_mode : DFT controls, no functional effect
//   scan_out0..4           : DFT chain outputs, tied low in RTL
// ============================================================================
module wishbone_slave_regs #(
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [7:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    input  logic        scan_in0,
    input  logic        scan_in1,
    input  logic        scan_in2,
    input  logic        scan_in3,
    input  logic        scan_in4,
    input  logic        scan_enable,
    input  logic        test_mode,
    output logic        scan_out0,
    output logic        scan_out1,
    output logic        scan_out2,
    output logic        scan_out3,
    output logic        scan_out4
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    // Counter value of the last WAIT cycle. Unused when WAIT_STATES = 0
    // because WAIT is never entered in that configuration.
    localparam logic [2:0] LP_WAIT_LAST =
        (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State and captured transfer
    // ------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_wait_cnt;
    logic [2:0]  w_wait_cnt_next;

    logic        r_we;
    logic [7:2]  r_adr;
    logic [31:0] r_dat;
    logic [3:0]  r_sel;

    logic        w_start;
    logic        w_go_resp;

    // Transfer fields as seen at the edge entering RESP. With zero wait
    // states that edge is also the capture edge, so the live bus is used
    // while still in IDLE and the captured copy otherwise.
    logic        w_cur_we;
    logic [7:2]  w_cur_adr;
    logic [31:0] w_cur_dat;
    logic [3:0]  w_cur_sel;
    logic [3:0]  w_idx;
    logic        w_in_range;
    logic        w_ack_term;

    logic [15:0][31:0] w_regs;

    logic        r_ack_o;
    logic [31:0] r_dat_o;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 3'd0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    assign w_start = (r_state == ST_IDLE) && wb_cyc_i && wb_stb_i;

    // ------------------------------------------------------------------
    // FSM: next state and RESP entry strobe
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_go_resp       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_wait_cnt_next = 3'd0;
                    if (WAIT_STATES == 0) begin
                        w_state_next = ST_RESP;
                        w_go_resp    = 1'b1;
                    end else begin
                        w_state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // A master dropping cyc abandons the transfer silently.
                if (!wb_cyc_i) begin
                    w_state_next    = ST_IDLE;
                    w_wait_cnt_next = 3'd0;
                end else if (r_wait_cnt == LP_WAIT_LAST) begin
                    w_state_next    = ST_RESP;
                    w_wait_cnt_next = 3'd0;
                    w_go_resp       = 1'b1;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + 3'd1;
                end
            end
            ST_RESP: begin
                // Always pass through IDLE; a still-high strobe is picked
                // up there on the following edge.
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next    = ST_IDLE;
                w_wait_cnt_next = 3'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Transfer capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we  <= 1'b0;
            r_adr <= '0;
            r_dat <= '0;
            r_sel <= '0;
        end else if (w_start) begin
            r_we  <= wb_we_i;
            r_adr <= wb_adr_i[7:2];
            r_dat <= wb_dat_i;
            r_sel <= wb_sel_i;
        end
    end

    assign w_cur_we   = (r_state == ST_IDLE) ? wb_we_i        : r_we;
    assign w_cur_adr  = (r_state == ST_IDLE) ? wb_adr_i[7:2]  : r_adr;
    assign w_cur_dat  = (r_state == ST_IDLE) ? wb_dat_i       : r_dat;
    assign w_cur_sel  = (r_state == ST_IDLE) ? wb_sel_i       : r_sel;
    assign w_idx      = w_cur_adr[5:2];
    assign w_in_range = (w_cur_adr[7:6] == 2'b00);

    // ------------------------------------------------------------------
    // Register file: 15 writable registers plus the ID constant
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 15; gi++) begin : g_reg
            logic [31:0] r_value;
            logic        w_wr_en;

            assign w_wr_en = w_go_resp && w_cur_we && w_in_range &&
                             (w_idx == 4'(gi));

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_value <= '0;
                end else if (w_wr_en) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_cur_sel[b]) begin
                            r_value[8*b +: 8] <= w_cur_dat[8*b +: 8];
                        end
                    end
                end
            end

            assign w_regs[gi] = r_value;
        end
    endgenerate

    assign w_regs[15] = ID_VALUE;

    // ------------------------------------------------------------------
    // Termination and read data, registered on the edge entering RESP so
    // they are high exactly for the single RESP cycle.
    // ------------------------------------------------------------------
`ifdef WB_SLAVE_ERR_EN
    logic r_err_o;

    assign w_ack_term = w_in_range;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_o <= 1'b0;
        end else begin
            r_err_o <= w_go_resp && !w_in_range;
        end
    end

    assign wb_err_o = r_err_o;
`else
    assign w_ack_term = 1'b1;
    assign wb_err_o   = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ack_o <= 1'b0;
            r_dat_o <= '0;
        end else begin
            r_ack_o <= w_go_resp && w_ack_term;
            // Full 32-bit word regardless of byte selects; out-of-range
            // reads and all writes present zero.
            if (w_go_resp && !w_cur_we && w_in_range) begin
                r_dat_o <= w_regs[w_idx];
            end else begin
                r_dat_o <= '0;
            end
        end
    end

    assign wb_ack_o = r_ack_o;
    assign wb_dat_o = r_dat_o;

    // ------------------------------------------------------------------
    // DFT placeholders: chain is stitched in after synthesis.
    // ------------------------------------------------------------------
    assign scan_out0 = 1'b0;
    assign scan_out1 = 1'b0;
    assign scan_out2 = 1'b0;
    assign scan_out3 = 1'b0;
    assign scan_out4 = 1'b0;

    logic w_unused_ok;
    assign w_unused_ok = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                           scan_enable, test_mode, wb_adr_i[1:0]};

endmodule

// File: tb/tb_wishbone_slave_regs.sv
// ============================================================================
// tb_wishbone_slave_regs
// ----------------------------------------------------------------------------
// Directed bench for wishbone_slave_regs. Instance u_dut0 uses the default
// WAIT_STATES = 2; instance u_dut1 uses WAIT_STATES = 0 for the
// back-to-back read sequence. Expected responses are pushed to a queue when
// a transfer is driven and popped when the DUT terminates it.
// ============================================================================
module tb_wishbone_slave_regs;

    localparam int WS = 2;
`ifdef WB_SLAVE_ERR_EN
    localparam bit OOR_ERR = 1'b1;
`else
    localparam bit OOR_ERR = 1'b0;
`endif

    typedef struct {
        logic        ack;
        logic        err;
        logic [31:0] dat;
    } exp_t;

    exp_t sb_q[$];

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // shared DFT inputs
    logic [4:0] scan_in;
    logic       scan_enable;
    logic       test_mode;

    // u_dut0 bus
    logic        cyc0, stb0, we0;
    logic [7:0]  adr0;
    logic [31:0] dati0;
    logic [3:0]  sel0;
    logic [31:0] dato0;
    logic        ack0, err0;
    logic [4:0]  so0;

    // u_dut1 bus
    logic        cyc1, stb1, we1;
    logic [7:0]  adr1;
    logic [31:0] dati1;
    logic [3:0]  sel1;
    logic [31:0] dato1;
    logic        ack1, err1;
    logic [4:0]  so1;

    int n_tests = 0;
    int n_fail  = 0;

    wishbone_slave_regs #(.WAIT_STATES(WS), .ID_VALUE(32'hA5B0_0001)) u_dut0 (
        .clk(clk), .reset(reset),
        .wb_cyc_i(cyc0), .wb_stb_i(stb0), .wb_we_i(we0), .wb_adr_i(adr0),
        .wb_dat_i(dati0), .wb_sel_i(sel0), .wb_dat_o(dato0),
        .wb_ack_o(ack0), .wb_err_o(err0),
        .scan_in0(scan_in[0]), .scan_in1(scan_in[1]), .scan_in2(scan_in[2]),
        .scan_in3(scan_in[3]), .scan_in4(scan_in[4]),
        .scan_enable(scan_enable), .test_mode(test_mode),
        .scan_out0(so0[0]), .scan_out1(so0[1]), .scan_out2(so0[2]),
        .scan_out3(so0[3]), .scan_out4(so0[4])
    );

    wishbone_slave_regs #(.WAIT_STATES(0), .ID_VALUE(32'hA5B0_0001)) u_dut1 (
        .clk(clk), .reset(reset),
        .wb_cyc_i(cyc1), .wb_stb_i(stb1), .wb_we_i(we1), .wb_adr_i(adr1),
        .wb_dat_i(dati1), .wb_sel_i(sel1), .wb_dat_o(dato1),
        .wb_ack_o(ack1), .wb_err_o(err1),
        .scan_in0(scan_in[0]), .scan_in1(scan_in[1]), .scan_in2(scan_in[2]),
        .scan_in3(scan_in[3]), .scan_in4(scan_in[4]),
        .scan_enable(scan_enable), .test_mode(test_mode),
        .scan_out0(so1[0]), .scan_out1(so1[1]), .scan_out2(so1[2]),
        .scan_out3(so1[3]), .scan_out4(so1[4])
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete classic transfer on u_dut0 with latency, scoreboard and
    // single-cycle-pulse checks.
    task automatic xfer0(input string tag, input logic we, input logic [7:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel,
                         input logic exp_err, input logic [31:0] exp_dat);
        exp_t e;
        int   n;
        @(negedge clk);
        cyc0 = 1'b1; stb0 = 1'b1; we0 = we; adr0 = adr; dati0 = dat; sel0 = sel;
        sb_q.push_back('{ack: !exp_err, err: exp_err, dat: exp_dat});
        @(posedge clk);                       // capture edge
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (ack0 || err0) break;
        end
        check({tag, "_latency"}, 32'(n), 32'(WS + 1));
        e = sb_q.pop_front();
        check({tag, "_ack"}, {31'b0, ack0}, {31'b0, e.ack});
        check({tag, "_err"}, {31'b0, err0}, {31'b0, e.err});
        check({tag, "_dat"}, dato0, e.dat);
        $display("[TB] %s we=%0b adr=%h dat=%h sel=%h -> ack=%0b err=%0b rdat=%h",
                 tag, we, adr, dat, sel, ack0, err0, dato0);
        cyc0 = 1'b0; stb0 = 1'b0; we0 = 1'b0;
        @(negedge clk);
        check({tag, "_pulse"}, {30'b0, ack0, err0}, 32'h0);
    endtask

    // Start a write on u_dut0 and abandon it during WAIT, either by dropping
    // cyc or by asserting reset.
    task automatic abort0(input string tag, input logic use_reset);
        int hits;
        @(negedge clk);
        cyc0 = 1'b1; stb0 = 1'b1; we0 = 1'b1; adr0 = 8'h0C;
        dati0 = 32'hCAFE_F00D; sel0 = 4'hF;
        @(posedge clk);
        @(negedge clk);                       // one cycle spent in WAIT
        if (use_reset) reset = 1'b1;
        cyc0 = 1'b0; stb0 = 1'b0; we0 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        hits = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (ack0 || err0) hits++;
        end
        check({tag, "_noterm"}, 32'(hits), 32'h0);
        $display("[TB] %s abort (reset=%0b) terminations=%0d", tag, use_reset, hits);
    endtask

    // Single write on u_dut1 (zero wait states).
    task automatic write1(input logic [7:0] adr, input logic [31:0] dat);
        @(negedge clk);
        cyc1 = 1'b1; stb1 = 1'b1; we1 = 1'b1; adr1 = adr; dati1 = dat; sel1 = 4'hF;
        @(posedge clk);
        @(negedge clk);
        check("ws0_wr_ack", {31'b0, ack1}, 32'h1);
        $display("[TB] ws0_wr adr=%h dat=%h ack=%0b", adr, dat, ack1);
        cyc1 = 1'b0; stb1 = 1'b0; we1 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0]  b_adr [4];
        logic [31:0] b_val [4];
        exp_t        e;
        int          k;
        int          acks;

        scan_in = '0; scan_enable = 1'b0; test_mode = 1'b0;
        cyc0 = 0; stb0 = 0; we0 = 0; adr0 = '0; dati0 = '0; sel0 = '0;
        cyc1 = 0; stb1 = 0; we1 = 0; adr1 = '0; dati1 = '0; sel1 = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ack0", {31'b0, ack0}, 32'h0);
        check("rst_err0", {31'b0, err0}, 32'h0);
        check("rst_dat0", dato0, 32'h0);
        check("rst_dat1", dato1, 32'h0);
        check("scan_out", {22'b0, so0, so1}, 32'h0);
        reset = 1'b0;

        // basic write / read
        xfer0("wr04", 1'b1, 8'h04, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0);
        xfer0("rd04", 1'b0, 8'h04, 32'h0, 4'hF, 1'b0, 32'hDEAD_BEEF);
        xfer0("rd07", 1'b0, 8'h07, 32'h0, 4'h1, 1'b0, 32'hDEAD_BEEF);

        // byte lanes; read with sel=0 still returns the whole word
        xfer0("wr08a", 1'b1, 8'h08, 32'h1122_3344, 4'hF, 1'b0, 32'h0);
        xfer0("wr08b", 1'b1, 8'h08, 32'hAABB_CCDD, 4'b0101, 1'b0, 32'h0);
        xfer0("rd08", 1'b0, 8'h08, 32'h0, 4'h0, 1'b0, 32'h11BB_33DD);

        // read-only ID register
        xfer0("rd3c", 1'b0, 8'h3C, 32'h0, 4'hF, 1'b0, 32'hA5B0_0001);
        xfer0("wr3c", 1'b1, 8'h3C, 32'h0, 4'hF, 1'b0, 32'h0);
        xfer0("rd3c2", 1'b0, 8'h3C, 32'h0, 4'hF, 1'b0, 32'hA5B0_0001);

        // out of range: no aliasing onto register 0
        xfer0("rd40", 1'b0, 8'h40, 32'h0, 4'hF, OOR_ERR, 32'h0);
        xfer0("wr40", 1'b1, 8'h40, 32'hFFFF_FFFF, 4'hF, OOR_ERR, 32'h0);
        xfer0("rd00", 1'b0, 8'h00, 32'h0, 4'hF, 1'b0, 32'h0);

        // aborts
        abort0("abort_cyc", 1'b0);
        xfer0("rd0c_a", 1'b0, 8'h0C, 32'h0, 4'hF, 1'b0, 32'h0);
        abort0("abort_rst", 1'b1);
        xfer0("rd0c_b", 1'b0, 8'h0C, 32'h0, 4'hF, 1'b0, 32'h0);
        xfer0("rd04_rst", 1'b0, 8'h04, 32'h0, 4'hF, 1'b0, 32'h0);

        // zero-wait-state back-to-back reads on u_dut1
        b_adr[0] = 8'h00; b_val[0] = 32'h0101_1010;
        b_adr[1] = 8'h04; b_val[1] = 32'h2222_3333;
        b_adr[2] = 8'h08; b_val[2] = 32'h4455_6677;
        b_adr[3] = 8'h3C; b_val[3] = 32'hA5B0_0001;
        for (int i = 0; i < 3; i++) write1(b_adr[i], b_val[i]);

        @(negedge clk);
        cyc1 = 1'b1; stb1 = 1'b1; we1 = 1'b0; sel1 = 4'hF; adr1 = b_adr[0];
        sb_q.push_back('{ack: 1'b1, err: 1'b0, dat: b_val[0]});
        k = 1;
        acks = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check($sformatf("b2b_ack_c%0d", c), {31'b0, ack1},
                  (c % 2 == 0) ? 32'h1 : 32'h0);
            if (ack1) begin
                acks++;
                e = sb_q.pop_front();
                check($sformatf("b2b_dat%0d", acks), dato1, e.dat);
                $display("[TB] b2b read #%0d adr=%h rdat=%h", acks, adr1, dato1);
                if (k < 4) begin
                    adr1 = b_adr[k];
                    sb_q.push_back('{ack: 1'b1, err: 1'b0, dat: b_val[k]});
                    k++;
                end
            end
        end
        cyc1 = 1'b0; stb1 = 1'b0;
        check("b2b_acks", 32'(acks), 32'd4);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
